// File: rtl/prime_gpio_pkg.sv
// Shared register map, status codes and engine state encoding for the
// multi-channel prime-index GPIO block.
package prime_gpio_pkg;

  localparam logic [7:0] OFF_A = 8'hD4;
  localparam logic [7:0] OFF_W = 8'hE4;
  localparam logic [7:0] OFF_S = 8'hEC;

  typedef enum logic [7:0] {
    S_IDLE    = 8'h00,
    S_PENDING = 8'hDD,
    S_BUSY    = 8'hCC,
    S_DONE    = 8'hEE,
    S_ERROR   = 8'hFF
  } s_code_e;

  typedef enum logic [2:0] {
    ENG_IDLE = 3'd0,
    ENG_LOAD = 3'd1,
    ENG_TEST = 3'd2,
    ENG_NEXT = 3'd3,
    ENG_DONE = 3'd4
  } eng_state_e;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/prime_gpio_mc_if.sv
// Register-bus bundle between a host and the prime GPIO block.
interface prime_gpio_mc_if #(parameter int DATA_W = 32);
  logic [15:0]       saddress;
  logic              srd;
  logic              swr;
  logic [DATA_W-1:0] sdata_in;
  logic [DATA_W-1:0] sdata_out;

  modport master (output saddress, srd, swr, sdata_in, input sdata_out);
  modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/prime_core.sv
// Trial-division engine: finds the index-th prime, one divisor test per cycle.
module prime_core
  import prime_gpio_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] index,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  eng_state_e        state_r;
  logic [DATA_W-1:0] idx_r;
  logic [DATA_W-1:0] cand_r;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W-1:0] count_r;
  logic [DATA_W-1:0] result_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] sq_s;
  logic              divides_s;

  assign sq_s      = div_r * div_r;
  assign divides_s = (div_r != {DATA_W{1'b0}}) && ((cand_r % div_r) == {DATA_W{1'b0}});

  // Engine sequencing; candidates after 2 are odd, so only odd divisors from 3 are tried
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ENG_IDLE;
      idx_r    <= {DATA_W{1'b0}};
      cand_r   <= {DATA_W{1'b0}};
      div_r    <= {DATA_W{1'b0}};
      count_r  <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (abort) begin
      state_r <= ENG_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ENG_IDLE: begin
          if (start) begin
            idx_r   <= index;
            busy_r  <= 1'b1;
            state_r <= ENG_LOAD;
          end
        end
        ENG_LOAD: begin
          cand_r  <= DATA_W'(2);
          div_r   <= DATA_W'(2);
          count_r <= {DATA_W{1'b0}};
          state_r <= ENG_TEST;
        end
        ENG_TEST: begin
          if (sq_s > cand_r) begin
            count_r <= count_r + DATA_W'(1);
            state_r <= (count_r + DATA_W'(1) == idx_r) ? ENG_DONE : ENG_NEXT;
          end else if (divides_s) begin
            state_r <= ENG_NEXT;
          end else begin
            div_r <= div_r + DATA_W'(2);
          end
        end
        ENG_NEXT: begin
          cand_r  <= (cand_r == DATA_W'(2)) ? DATA_W'(3) : cand_r + DATA_W'(2);
          div_r   <= DATA_W'(3);
          state_r <= ENG_TEST;
        end
        ENG_DONE: begin
          result_r <= cand_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ENG_IDLE;
        end
        default: state_r <= ENG_IDLE;
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: rtl/prime_gpio_mc.sv
// Multi-channel prime-index GPIO block: per-channel A/W/S registers,
// round-robin sharing of one prime_core, GPIO result and input snapshot.
module prime_gpio_mc
  import prime_gpio_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int MAX_N  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  prime_gpio_mc_if.slave        bus,
  input  logic [31:0]           gpio_in,
  input  logic                  gpio_latch,
  output logic [31:0]           gpio_out,
  output logic [31:0]           gpio_in_s_insp
);

  logic [DATA_W-1:0] a_r [N_CH];
  logic [DATA_W-1:0] w_r [N_CH];
  s_code_e           s_r [N_CH];
  logic [7:0]        rr_ptr_r;
  logic [7:0]        cur_ch_r;
  logic              active_r;
  logic [DATA_W-1:0] sdata_out_r;
  logic [31:0]       gpio_out_r;
  logic [31:0]       snap_r;

  logic [7:0]        ch_s;
  logic [7:0]        off_s;
  logic              ch_ok_s;
  logic              wr_a_s;
  logic              a_legal_s;
  logic              found_s;
  int                grant_idx_s;
  int                scan_k_s;
  logic [7:0]        grant_ch_s;
  logic              start_s;
  logic              abort_s;
  logic              fin_s;
  logic              core_busy_s;
  logic              core_done_s;
  logic [DATA_W-1:0] core_result_s;
  logic [DATA_W-1:0] rd_val_s;

  assign ch_s      = bus.saddress[15:8];
  assign off_s     = bus.saddress[7:0];
  assign ch_ok_s   = (ch_s < 8'(N_CH));
  assign wr_a_s    = bus.swr && ch_ok_s && (off_s == OFF_A);
  assign a_legal_s = (bus.sdata_in != {DATA_W{1'b0}}) && (bus.sdata_in <= DATA_W'(MAX_N));

  // Round-robin scan for the first PENDING channel starting at the next-to-serve pointer
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 0;
    scan_k_s    = 0;
    for (int i = 0; i < N_CH; i++) begin
      scan_k_s = wrap_idx(int'(rr_ptr_r) + i, N_CH);
      if (!found_s && s_r[scan_k_s] == S_PENDING) begin
        found_s     = 1'b1;
        grant_idx_s = scan_k_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_ch_s = 8'(grant_idx_s);
  // Grants wait one cycle when A is being written, so the engine never loads a stale A
  assign start_s = found_s && !active_r && !core_busy_s && !wr_a_s;
  assign abort_s = active_r && wr_a_s && (ch_s == cur_ch_r);
  assign fin_s   = core_done_s && active_r && !abort_s;

  prime_core #(.DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .abort  (abort_s),
    .index  (a_r[grant_idx_s]),
    .busy   (core_busy_s),
    .done   (core_done_s),
    .result (core_result_s)
  );

  // Per-channel register file; a host write to A beats a same-cycle completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        a_r[i] <= {DATA_W{1'b0}};
        w_r[i] <= {DATA_W{1'b0}};
        s_r[i] <= S_IDLE;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_a_s && ch_s == 8'(i)) begin
          a_r[i] <= bus.sdata_in;
          w_r[i] <= {DATA_W{1'b0}};
          s_r[i] <= a_legal_s ? S_PENDING : S_ERROR;
        end else if (fin_s && cur_ch_r == 8'(i)) begin
          w_r[i] <= core_result_s;
          s_r[i] <= S_DONE;
        end else if (start_s && grant_ch_s == 8'(i)) begin
          s_r[i] <= S_BUSY;
        end
      end
    end
  end

  // Engine ownership, round-robin pointer and GPIO result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r   <= 1'b0;
      cur_ch_r   <= 8'd0;
      rr_ptr_r   <= 8'd0;
      gpio_out_r <= 32'd0;
    end else begin
      if (abort_s || core_done_s) begin
        active_r <= 1'b0;
      end else if (start_s) begin
        active_r <= 1'b1;
        cur_ch_r <= grant_ch_s;
        rr_ptr_r <= 8'(wrap_idx(grant_idx_s + 1, N_CH));
      end
      if (fin_s) begin
        gpio_out_r <= 32'(core_result_s);
      end
    end
  end

  // Read mux: unmapped offsets and out-of-range channels read as zero
  always_comb begin
    rd_val_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (ch_s == 8'(i)) begin
        case (off_s)
          OFF_A:   rd_val_s = a_r[i];
          OFF_W:   rd_val_s = w_r[i];
          OFF_S:   rd_val_s = DATA_W'(s_r[i]);
          default: rd_val_s = {DATA_W{1'b0}};
        endcase
      end else begin
        rd_val_s = rd_val_s;
      end
    end
  end

  // Registered read data and GPIO input snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdata_out_r <= {DATA_W{1'b0}};
      snap_r      <= 32'd0;
    end else begin
      if (bus.srd) begin
        sdata_out_r <= rd_val_s;
      end
      if (gpio_latch) begin
        snap_r <= gpio_in;
      end
    end
  end

  assign bus.sdata_out  = sdata_out_r;
  assign gpio_out       = gpio_out_r;
  assign gpio_in_s_insp = snap_r;

endmodule

// File: doc/prime_gpio_mc.md
PRIME_GPIO_MC -- requirements
Module: prime_gpio_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent request channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32: width of the bus data and of the A/W registers.
REQ-003 SHALL have parameter MAX_N, default 2048: largest legal prime index A.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port saddress  input  16  [15:8] = channel index, [7:0] = register offset.
REQ-007 SHALL have ports srd and swr  input  1 each  read and write strobes, sampled on clk.
REQ-008 SHALL have port sdata_in  input  DATA_W  write data.
REQ-009 SHALL have port sdata_out  output  DATA_W  registered read data.
REQ-010 SHALL have ports gpio_in  input  32, and gpio_latch  input  1.
REQ-011 SHALL have port gpio_out  output  32  low 32 bits of the most recently completed result.
REQ-012 SHALL have port gpio_in_s_insp  output  32  latched gpio_in snapshot.

Function
REQ-013 SHALL map per channel: offset 0xD4 = A (RW, prime index), 0xE4 = W (RO, result), 0xEC = S (RO, status).
REQ-014 SHALL encode S as: 0x00 IDLE, 0xDD PENDING, 0xCC BUSY, 0xEE DONE, 0xFF ERROR.
REQ-015 SHALL, on swr to A with 1 <= value <= MAX_N, store A, clear W to 0, and set S to PENDING on the next edge.
REQ-016 SHALL, on swr to A with value 0 or value > MAX_N, store A, clear W, and set S to ERROR without queuing.
REQ-017 SHALL ignore writes to W, S, unmapped offsets, or channel index >= N_CH; no state changes.
REQ-018 SHALL drive sdata_out one cycle after srd with the addressed register; it SHALL drive 0 for unmapped addresses and hold the last value when srd is low.
REQ-019 SHALL share one prime engine among channels; when idle, it SHALL pick a PENDING channel round-robin, starting after the last served channel (channel 0 first after reset).
REQ-020 SHALL use engine states IDLE -> LOAD -> TEST -> NEXT -> DONE -> IDLE.
REQ-021 In TEST, the engine SHALL check one trial divisor d per cycle (d=2.., d*d <= candidate); a candidate with no divisor increments the prime count.
REQ-022 When the count reaches A, the engine SHALL write the prime into W, set S to DONE, and update gpio_out on the same edge.
REQ-023 SHALL, on a write to A of the BUSY channel, abort the engine within 1 cycle and requeue that channel with the new A (PENDING).
REQ-024 SHALL, when a write to A and completion hit the same channel in one cycle, apply the write and discard the result.
REQ-025 SHALL, on a write to A of a PENDING channel, replace A in place without losing queue position.
REQ-026 SHALL sample gpio_in into gpio_in_s_insp on every clk edge where gpio_latch = 1.
REQ-027 SHALL keep the candidate and divisor registers at DATA_W bits, with no overflow for MAX_N <= 2048.

Reset
REQ-028 SHALL clear, while reset = 1, all A, W, and S registers, sdata_out, gpio_out, gpio_in_s_insp, the RR pointer, and the engine (to IDLE), asynchronously.
REQ-029 SHALL, when reset is asserted mid-computation, discard the computation; after release, no channel is PENDING.

Structure
REQ-030 SHALL place offsets 0xD4/0xE4/0xEC, the S codes, and the engine state enum in a shared package prime_gpio_pkg.
REQ-031 SHALL implement the engine as sub-module prime_core (start, abort, index in; busy, done, result out); arbitration and register file stay in the top level.

Verification
REQ-032 SHALL cover: ch0 A=0x18 -> S=0xCC while computing, then W=0x59, S=0xEE, gpio_out=0x59.
REQ-033 SHALL cover: ch0 A=0x3E8 -> W=0x1EEF; ch2 A=0 -> S=0xFF, W=0, engine untouched.
REQ-034 SHALL cover: ch0 A=0xF and ch1 A=0x8 written back-to-back -> ch0 W=0x2F completes first, then ch1 W=0x13.
REQ-035 SHALL cover: ch1 A=0x3E8, then A=0x8 while BUSY -> W=0x13, and no 0x1EEF ever appears in W.
REQ-036 SHALL cover: write 0x25 to offset 0xAA, then read offset 0xBB -> all registers unchanged, sdata_out=0.
REQ-037 SHALL cover: reset pulse during ch0 BUSY -> all S=0x00, W=0, gpio_out=0; gpio_latch=1 with gpio_in=0xA5A5A5A5 -> gpio_in_s_insp=0xA5A5A5A5.
